// File: rtl/queue_tx_pkg.sv
// Shared types and default parameters for the queue-fed serial transmitter.
package queue_tx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } tx_state_t;

    localparam int DEFAULT_WIDTH        = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 4;

endpackage

// File: rtl/queue_tx_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each period.
module queue_tx_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count_r;

    assign tick = (count_r == LAST);

    // Period counter; wraps at the end of each bit and restarts on state changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (clear || tick) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + CW'(1);
        end
    end

endmodule

// File: rtl/queue_serial_tx.sv
// Pops entries from the FIFO queue and sends each as start + WIDTH data bits (LSB first) + stop.
module queue_serial_tx
    import queue_tx_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             q_empty,
    input  logic [WIDTH-1:0] q_data,
    output logic             q_dequeue,
    output logic             tx,
    output logic             busy
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);

    if (CLKS_PER_BIT < 2) begin : g_clks_check
        $fatal(1, "queue_serial_tx: CLKS_PER_BIT must be at least 2");
    end

    tx_state_t        state_r;
    tx_state_t        state_s;
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] shift_s;
    logic [IW-1:0]    idx_r;
    logic [IW-1:0]    idx_s;
    logic             tx_r;
    logic             tx_s;
    logic             busy_r;
    logic             tick_s;
    logic             clear_s;
    logic             dequeue_s;

    // Pop is gated by reset so nothing is lost from the queue while held in reset.
    assign dequeue_s = !rst && (state_r == IDLE) && enable && !q_empty;
    assign clear_s   = (state_s != state_r);
    assign q_dequeue = dequeue_s;
    assign tx        = tx_r;
    assign busy      = busy_r;

    queue_tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(clear_s),
        .tick (tick_s)
    );

    // Next-state, shift register and bit-index logic.
    always_comb begin
        state_s = state_r;
        shift_s = shift_r;
        idx_s   = idx_r;
        case (state_r)
            IDLE: begin
                if (dequeue_s) begin
                    state_s = FETCH;
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                shift_s = q_data;
                state_s = START;
            end
            START: begin
                if (tick_s) begin
                    state_s = DATA;
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (tick_s) begin
                    shift_s = shift_r >> 1'b1;
                    if (idx_r == LAST_BIT) begin
                        idx_s   = '0;
                        state_s = STOP;
                    end else begin
                        idx_s   = idx_r + IW'(1);
                        state_s = DATA;
                    end
                end else begin
                    state_s = DATA;
                end
            end
            STOP: begin
                if (tick_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Line level is computed from the next state so the register lines up with the state.
    always_comb begin
        tx_s = 1'b1;
        case (state_s)
            START:   tx_s = 1'b0;
            DATA:    tx_s = shift_s[0];
            default: tx_s = 1'b1;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            shift_r <= '0;
            idx_r   <= '0;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            shift_r <= shift_s;
            idx_r   <= idx_s;
            tx_r    <= tx_s;
            busy_r  <= (state_s != IDLE);
        end
    end

endmodule

// File: tb/tb_queue_serial_tx.sv
// Directed bench for queue_serial_tx: reset, single/back-to-back frames, enable drop, mid-frame reset, small-parameter frame.
module tb_queue_serial_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       q_empty;
    logic [7:0] q_data;
    logic       q_dequeue;
    logic       tx;
    logic       busy;

    logic       rst2;
    logic       enable2;
    logic       q_empty2;
    logic [3:0] q_data2;
    logic       q_dequeue2;
    logic       tx2;
    logic       busy2;

    int ncomp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    queue_serial_tx u_dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .q_empty  (q_empty),
        .q_data   (q_data),
        .q_dequeue(q_dequeue),
        .tx       (tx),
        .busy     (busy)
    );

    queue_serial_tx #(
        .WIDTH       (4),
        .CLKS_PER_BIT(2)
    ) u_dut2 (
        .clk      (clk),
        .rst      (rst2),
        .enable   (enable2),
        .q_empty  (q_empty2),
        .q_data   (q_data2),
        .q_dequeue(q_dequeue2),
        .tx       (tx2),
        .busy     (busy2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge of the FETCH cycle; checks the 40 frame cycles that follow.
    task automatic check_frame(input logic [7:0] data, input string tag, input int en_off_k);
        logic [7:0] dec;
        logic       eb;
        int         b;
        dec = 8'h00;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            b = k / 4;
            if (b == 0)      eb = 1'b0;
            else if (b == 9) eb = 1'b1;
            else             eb = data[b-1];
            chk({tag, " tx"}, {31'd0, tx}, {31'd0, eb});
            chk({tag, " busy"}, {31'd0, busy}, 32'd1);
            chk({tag, " no pop mid-frame"}, {31'd0, q_dequeue}, 32'd0);
            if ((k % 4 == 2) && (b >= 1) && (b <= 8)) dec[b-1] = tx;
            if (k == en_off_k) enable = 1'b0;
        end
        chk({tag, " decoded"}, {24'd0, dec}, {24'd0, data});
    endtask

    initial begin
        logic [3:0] d2;
        logic       eb2;
        int         b2;

        rst      = 1'b1;
        enable   = 1'b1;
        q_empty  = 1'b0;
        q_data   = 8'h00;
        rst2     = 1'b1;
        enable2  = 1'b0;
        q_empty2 = 1'b1;
        q_data2  = 4'h0;

        // Reset held for two cycles with a non-empty queue.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            chk("reset tx", {31'd0, tx}, 32'd1);
            chk("reset q_dequeue", {31'd0, q_dequeue}, 32'd0);
            chk("reset busy", {31'd0, busy}, 32'd0);
            chk("reset2 tx", {31'd0, tx2}, 32'd1);
            chk("reset2 busy", {31'd0, busy2}, 32'd0);
        end

        // Single frame 0x55: pop on the first cycle after reset.
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("first pop after reset", {31'd0, q_dequeue}, 32'd1);
        chk("idle busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        q_data  = 8'h55;
        q_empty = 1'b1;
        #1;
        chk("fetch busy", {31'd0, busy}, 32'd1);
        chk("fetch tx", {31'd0, tx}, 32'd1);
        check_frame(8'h55, "f55", -1);
        @(negedge clk);
        #1;
        chk("f55 busy falls", {31'd0, busy}, 32'd0);
        chk("f55 no pop empty", {31'd0, q_dequeue}, 32'd0);

        // Back-to-back 0xA5, 0x3C from a two-entry queue.
        @(negedge clk);
        q_empty = 1'b0;
        #1;
        chk("b2b pop1", {31'd0, q_dequeue}, 32'd1);
        @(negedge clk);
        q_data = 8'hA5;
        check_frame(8'hA5, "fA5", -1);
        @(negedge clk);
        #1;
        chk("b2b pop2 at +42", {31'd0, q_dequeue}, 32'd1);
        chk("b2b busy low between", {31'd0, busy}, 32'd0);
        chk("b2b tx idle between", {31'd0, tx}, 32'd1);
        @(negedge clk);
        q_data  = 8'h3C;
        q_empty = 1'b1;
        #1;
        chk("b2b fetch tx", {31'd0, tx}, 32'd1);
        check_frame(8'h3C, "f3C", -1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("b2b no third pop", {31'd0, q_dequeue}, 32'd0);
            chk("b2b idle busy", {31'd0, busy}, 32'd0);
        end

        // 0xFF with enable dropped 10 cycles into the frame.
        @(negedge clk);
        q_empty = 1'b0;
        #1;
        chk("en pop", {31'd0, q_dequeue}, 32'd1);
        @(negedge clk);
        q_data = 8'hFF;
        check_frame(8'hFF, "fFF", 8);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            chk("disabled no pop", {31'd0, q_dequeue}, 32'd0);
            chk("disabled idle", {31'd0, busy}, 32'd0);
        end
        @(negedge clk);
        enable = 1'b1;
        #1;
        chk("enable returns pop", {31'd0, q_dequeue}, 32'd1);

        // 0x0F interrupted by reset during data bit 4.
        @(negedge clk);
        q_data = 8'h0F;
        for (int i = 0; i < 20; i++) @(negedge clk);
        @(negedge clk);
        #1;
        chk("f0F bit4 low", {31'd0, tx}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("midreset tx", {31'd0, tx}, 32'd1);
        chk("midreset busy", {31'd0, busy}, 32'd0);
        chk("midreset no pop", {31'd0, q_dequeue}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post-reset pop", {31'd0, q_dequeue}, 32'd1);
        @(negedge clk);
        q_data  = 8'h81;
        q_empty = 1'b1;
        check_frame(8'h81, "f81", -1);
        @(negedge clk);
        #1;
        chk("f81 busy falls", {31'd0, busy}, 32'd0);

        // WIDTH=4, CLKS_PER_BIT=2 frame of 0x9.
        @(negedge clk);
        rst2     = 1'b0;
        enable2  = 1'b1;
        q_empty2 = 1'b0;
        #1;
        chk("p2 pop", {31'd0, q_dequeue2}, 32'd1);
        @(negedge clk);
        q_data2  = 4'h9;
        q_empty2 = 1'b1;
        #1;
        chk("p2 fetch busy", {31'd0, busy2}, 32'd1);
        d2 = 4'h9;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            #1;
            b2 = k / 2;
            if (b2 == 0)      eb2 = 1'b0;
            else if (b2 == 5) eb2 = 1'b1;
            else              eb2 = d2[b2-1];
            chk("p2 tx", {31'd0, tx2}, {31'd0, eb2});
            chk("p2 busy", {31'd0, busy2}, 32'd1);
        end
        @(negedge clk);
        #1;
        chk("p2 busy falls", {31'd0, busy2}, 32'd0);
        chk("p2 tx idle", {31'd0, tx2}, 32'd1);
        chk("p2 no pop empty", {31'd0, q_dequeue2}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule

// File: doc/queue_serial_tx.md
# queue_serial_tx

Downstream consumer for the parameterised FIFO queue. Whenever the queue is non-empty and the block is enabled, it pops one entry and transmits it on a single-wire asynchronous serial line. Frame format: start bit, WIDTH data bits LSB first, one stop bit. It connects directly to the queue's `dequeue`/`data_out`/`empty` pins and is the queue's only reader.

## Interface
- `WIDTH`, default 8: data width per entry; must match the queue.
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit; legal range is ≥ 2.
- `clk`  input  1  system clock; all logic is on its rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `enable`  input  1  permits starting new frames; does not affect a frame already in progress.
- `q_empty`  input  1  queue `empty` flag.
- `q_data`  input  WIDTH  queue `data_out`; valid the cycle after `q_dequeue` is asserted.
- `q_dequeue`  output  1  single-cycle pop request to queue `dequeue`.
- `tx`  output  1  serial line; idles high.
- `busy`  output  1  high whenever the state is not IDLE.

## Operation
- States:
  - IDLE: `tx`=1. If `enable` && !`q_empty`, assert `q_dequeue` this cycle and go to FETCH. Otherwise stay in IDLE.
  - FETCH: one cycle. Load `q_data` into the shift register at the end of the cycle, then go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: `tx`=shift[0] for each bit. Shift right every CLKS_PER_BIT cycles. After WIDTH bits, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles, then go to IDLE.
- `q_dequeue` is high only in IDLE cycles that take the transition. It is never high for two consecutive cycles and never high when `q_empty`=1.
- Bit-period counter counts 0..CLKS_PER_BIT-1 and clears on every state change. Its width is $clog2(CLKS_PER_BIT).
- Bit-index counter counts 0..WIDTH-1. Its width is $clog2(WIDTH), with a minimum of 1.
- Output drive:
  - `tx` is driven from a register, so there is no combinational path from the inputs.
  - `q_dequeue` is combinational from state, `enable` and `q_empty`.
- `enable` falling mid-frame: the frame completes normally. The block then stays in IDLE.
- `q_empty` changing after the pop: ignored. The data is already committed.

## Timing
- Reset values: `tx`=1, `q_dequeue`=0, `busy`=0, state=IDLE, counters=0, shift register=0.
- Reset mid-frame: the frame is aborted and the popped entry is lost. `tx`=1 on the cycle after reset is sampled.
- Latency: if pop is asserted in cycle N, the start bit begins in cycle N+2.
- Frame length is (WIDTH+2)·CLKS_PER_BIT cycles. With defaults: 40 cycles.
- Back-to-back frames: 2 extra idle-high cycles (IDLE + FETCH) between the stop bit and the next start bit. Period is 42 cycles with defaults.
- `busy` rises in cycle N+1 (the FETCH cycle) and falls in the first IDLE cycle after STOP.

## Structure
- Package `queue_tx_pkg`:
  - `typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} tx_state_t`.
  - Default-parameter localparams.
- One sub-module: `queue_tx_bit_timer`, the bit-period counter.
  - Inputs: `clk`, `rst`, `clear`.
  - Output: `tick`, high in the last cycle of each bit period.
  - The FSM, shift register and bit index stay in the top module.
- Elaboration-time check: CLKS_PER_BIT < 2 is a fatal error.

## Test plan
- Reset behaviour: hold `rst`=1 for 2 cycles with `q_empty`=0 and `enable`=1 → `tx`=1, `q_dequeue`=0 and `busy`=0 during reset. First pop occurs on the first cycle after reset deasserts.
- Single frame 0x55, defaults: pop at N, `q_data`=0x55 at N+1 → `tx` = 0 on [N+2, N+6), then bits 1,0,1,0,1,0,1,0 with 4 cycles each, then 1 for 4 cycles. `busy` falls at N+42.
- Back-to-back 0xA5 then 0x3C: queue holds 2 entries → exactly 2 `q_dequeue` pulses, 42 cycles apart. Decoded bytes are 0xA5 then 0x3C, and no pop occurs when `q_empty`=1 afterward.
- `enable` deasserted 10 cycles into a frame of 0xFF → the frame completes intact, and no further pop occurs while `q_empty`=0 until `enable` returns.
- Reset asserted in the DATA state of 0x0F → `tx`=1 and `busy`=0 on the next cycle. After release, the next queue entry is sent cleanly.
- Parameter sweep WIDTH=4, CLKS_PER_BIT=2 with data 0x9 → frame is 12 cycles: 0, then 1,0,0,1 LSB first, then 1.
